difftest_batch_receiver: RTL and testbench
==========================================

# difftest_batch_receiver

Receiving end of the difftest batch gateway on the FPGA. Captures each `BATCH_W`-bit batch presented on the core's gateway data/enable pair and buffers whole batches in a FIFO. Serializes each batch into 64-bit AXI4-Stream beats for the host DMA engine. The gateway has no backpressure, so batches arriving while the FIFO is full are dropped and counted.

## Interface
Parameters:
- `BATCH_W`, 1024: gateway batch width in bits; must be a multiple of 64 and ≥128.
- `FIFO_DEPTH`, 4: number of whole batches buffered; power of two, ≥2.

Ports:
- `sys_clk_i`  in  1  single clock for the whole block.
- `sys_rstn_i`  in  1  reset, asynchronous, active-low.
- `gw_data`  in  BATCH_W  batch payload; sampled only when `gw_enable`=1.
- `gw_enable`  in  1  one-cycle strobe; one batch per asserted cycle.
- `m_axis_tvalid`  out  1  stream beat valid.
- `m_axis_tready`  in  1  host accepts the beat.
- `m_axis_tdata`  out  64  stream beat payload.
- `m_axis_tlast`  out  1  last beat of a batch.
- `clr_stat`  in  1  synchronous clear of `drop_cnt` and `overflow`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  batches currently stored, including the batch being sent.
- `drop_cnt`  out  16  dropped batches; saturates at 16'hFFFF.
- `overflow`  out  1  sticky; set on the first drop.

## Operation
- Capture: a batch is written when `gw_enable`=1 and the FIFO is not full. Full means `fifo_level`==FIFO_DEPTH after accounting for a same-cycle pop.
- Drop: when `gw_enable`=1 and the FIFO is full with no same-cycle pop, the batch is discarded, `drop_cnt` increments (saturating) and `overflow` is set.
- `clr_stat` takes priority over a same-cycle drop: the counter ends at 0 and `overflow` ends at 0.
- Beat order is LSB first. Beat k carries `gw_data[64k+63:64k]`, for k = 0 to BATCH_W/64−1.
- The head batch is popped on the handshake of its `tlast` beat.
- State machine:
  - IDLE → DATA when the FIFO is non-empty; the beat counter is set to 0.
  - DATA advances the beat counter on each handshake. On the last-beat handshake it goes to DATA again if another batch is stored (no bubble), otherwise to IDLE.
- `tlast` = (beat counter == BATCH_W/64−1) && `tvalid`.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `fifo_level`=0, `drop_cnt`=0, `overflow`=0, state IDLE. Reset takes effect immediately and asynchronously, including mid-batch; a partly sent batch is lost.
- Latency: `gw_enable` at edge N gives `m_axis_tvalid`=1 in the cycle after edge N+1. This is 1 cycle when the block is idle.
- AXI-Stream rules:
  - `tdata`/`tlast` hold stable while `tvalid` && !`tready`.
  - `tvalid` never deasserts without a handshake.
  - `tvalid` does not depend combinationally on `tready`.
- Throughput: one beat per cycle with `tready` held at 1. Back-to-back batches stream with no idle cycle.
- Simultaneous write and pop while full: the write is accepted and `fifo_level` stays unchanged.

## Configuration
- `DIFFTEST_RX_SEQ_HDR_EN` defined:
  - Each batch is preceded by one header beat. Header `tdata` = {16'hDA7A, `drop_cnt`, seq[31:0]}, with `tlast`=0.
  - seq counts emitted batches, starts at 0 after reset and wraps at 2^32.
  - The state machine gains a HDR state (IDLE/DATA-last → HDR → DATA).
  - A batch is BATCH_W/64+1 beats.
- Not defined: no header, no seq counter, and no HDR state.

## Structure
- Package `difftest_rx_pkg`:
  - `AXIS_W`=64.
  - `HDR_MAGIC`=16'hDA7A.
  - the state enum (IDLE, HDR, DATA).
  - `DROP_CNT_W`=16.
- Sub-module `difftest_rx_fifo`:
  - synchronous show-ahead FIFO, `BATCH_W` wide and `FIFO_DEPTH` deep.
  - ports: push, pop, full, empty, level, head data.
- The top level holds the serializer FSM, the beat counter, a 64-bit beat mux and the statistics.

## Test plan
- Single batch, BATCH_W=1024, `gw_data` = 16 words 0x0..0xF, `tready`=1:
  - 16 beats in consecutive cycles with `tdata` 0,1,…,15.
  - `tlast` only on beat 15.
  - `fifo_level` returns to 0.
- Backpressure: `tready` toggles 1010… during the same batch → identical beat sequence, with `tdata` held on stalled cycles.
- Overflow: `tready`=0, FIFO_DEPTH=4, six `gw_enable` pulses → `fifo_level`=4, `drop_cnt`=2, `overflow`=1. Releasing `tready` delivers exactly the first 4 batches in order.
- Full plus simultaneous pop: FIFO full, `gw_enable` in the same cycle as a `tlast` handshake → batch accepted, `drop_cnt` unchanged.
- Reset mid-batch: assert `sys_rstn_i`=0 after beat 5 → `tvalid`=0 immediately and all outputs at reset values. The next batch starts at beat 0.
- With `DIFFTEST_RX_SEQ_HDR_EN`, two batches → header beats 0xDA7A_0000_00000000 and 0xDA7A_0000_00000001, each followed by 16 data beats.

Source files
------------

// File: rtl/difftest_rx_pkg.sv
// Shared constants and the serializer state type for the difftest batch receiver.
package difftest_rx_pkg;
  localparam int AXIS_W = 64;
  localparam logic [15:0] HDR_MAGIC = 16'hDA7A;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } rx_state_t;
endpackage

// File: rtl/difftest_rx_fifo.sv
// Show-ahead FIFO of whole batches; head is the oldest entry, head_next the one behind it.
module difftest_rx_fifo #(
  parameter int BATCH_W    = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [BATCH_W-1:0]            wdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [BATCH_W-1:0]            head,
  output logic [BATCH_W-1:0]            head_next
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  logic [BATCH_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [AW-1:0]      rd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A push while full only happens together with a pop, so the slot overwritten is the one leaving.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign rd_nxt    = rd_ptr[AW-1:0] + AW'(1);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_next = mem[rd_nxt];
endmodule

// File: rtl/difftest_batch_receiver.sv
// Gateway batch capture, FIFO buffering and 64-bit AXI4-Stream serialization.
// Optional per-batch header beat with sequence number: define DIFFTEST_RX_SEQ_HDR_EN.
module difftest_batch_receiver
  import difftest_rx_pkg::*;
#(
  parameter int BATCH_W    = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        sys_clk_i,
  input  logic                        sys_rstn_i,
  input  logic [BATCH_W-1:0]          gw_data,
  input  logic                        gw_enable,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tlast,
  input  logic                        clr_stat,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [DROP_CNT_W-1:0]       drop_cnt,
  output logic                        overflow
);
  localparam int BEATS = BATCH_W / AXIS_W;
  localparam int BCW   = $clog2(BEATS);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  rx_state_t          state;
  logic [BCW-1:0]     beat;
  logic [BCW-1:0]     beat_nxt;
  logic               fifo_full;
  logic               fifo_empty;
  logic [BATCH_W-1:0] head;
  logic [BATCH_W-1:0] head_next;
  logic               push;
  logic               pop;
  logic               drop;
`ifdef DIFFTEST_RX_SEQ_HDR_EN
  logic [31:0]        seq;
`endif

  function automatic logic [AXIS_W-1:0] beat_word(input logic [BATCH_W-1:0] b,
                                                  input logic [BCW-1:0] k);
    return b[int'(k)*AXIS_W +: AXIS_W];
  endfunction

  // Handshake: a beat transfers on a rising edge where tvalid && tready; tvalid/tdata/tlast are
  // registered, never depend on tready in the same cycle, and hold until that transfer.
  assign pop      = (state == DATA) && m_axis_tvalid && m_axis_tready && (beat == LAST_BEAT);
  assign push     = gw_enable && (!fifo_full || pop);
  assign drop     = gw_enable && fifo_full && !pop;
  assign beat_nxt = beat + 1'b1;

  difftest_rx_fifo #(
    .BATCH_W   (BATCH_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (sys_clk_i),
    .rst_n    (sys_rstn_i),
    .push     (push),
    .pop      (pop),
    .wdata    (gw_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .head     (head),
    .head_next(head_next)
  );

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clr_stat) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state         <= IDLE;
      beat          <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
`ifdef DIFFTEST_RX_SEQ_HDR_EN
      seq           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            beat          <= '0;
`ifdef DIFFTEST_RX_SEQ_HDR_EN
            state        <= HDR;
            m_axis_tdata <= {HDR_MAGIC, drop_cnt, seq};
`else
            state        <= DATA;
            m_axis_tdata <= beat_word(head, '0);
`endif
          end
        end
        HDR: begin
          if (m_axis_tready) begin
            state        <= DATA;
            beat         <= '0;
            m_axis_tdata <= beat_word(head, '0);
            m_axis_tlast <= 1'b0;
          end
        end
        DATA: begin
          if (m_axis_tready) begin
            if (beat == LAST_BEAT) begin
`ifdef DIFFTEST_RX_SEQ_HDR_EN
              seq <= seq + 1'b1;
`endif
              m_axis_tlast <= 1'b0;
              // The FIFO level still counts the batch being popped this cycle.
              if (fifo_level > LVL_W'(1)) begin
`ifdef DIFFTEST_RX_SEQ_HDR_EN
                state        <= HDR;
                m_axis_tdata <= {HDR_MAGIC, drop_cnt, seq + 32'd1};
`else
                state        <= DATA;
                beat         <= '0;
                m_axis_tdata <= beat_word(head_next, '0);
`endif
              end else begin
                state         <= IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
              end
            end else begin
              beat         <= beat_nxt;
              m_axis_tdata <= beat_word(head, beat_nxt);
              m_axis_tlast <= (beat_nxt == LAST_BEAT);
            end
          end
        end
        default: begin
          state         <= IDLE;
          m_axis_tvalid <= 1'b0;
          m_axis_tdata  <= '0;
          m_axis_tlast  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_difftest_batch_receiver.sv
// Bench for difftest_batch_receiver: batch-level reference model, beat capture and per-test checks.
module tb_difftest_batch_receiver;
  localparam int BATCH_W    = 1024;
  localparam int FIFO_DEPTH = 4;
  localparam int WORDS      = BATCH_W / 64;
`ifdef DIFFTEST_RX_SEQ_HDR_EN
  localparam int BPB = WORDS + 1;
`else
  localparam int BPB = WORDS;
`endif

  logic               sys_clk_i = 1'b0;
  logic               sys_rstn_i = 1'b0;
  logic [BATCH_W-1:0] gw_data;
  logic               gw_enable;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [63:0]        m_axis_tdata;
  logic               m_axis_tlast;
  logic               clr_stat;
  logic [2:0]         fifo_level;
  logic [15:0]        drop_cnt;
  logic               overflow;

  difftest_batch_receiver #(.BATCH_W(BATCH_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .sys_clk_i    (sys_clk_i),
    .sys_rstn_i   (sys_rstn_i),
    .gw_data      (gw_data),
    .gw_enable    (gw_enable),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .clr_stat     (clr_stat),
    .fifo_level   (fifo_level),
    .drop_cnt     (drop_cnt),
    .overflow     (overflow)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int total = 0;
  int bad   = 0;
  logic [63:0]        exp_q[$];
  bit                 exp_last[$];
  logic [63:0]        obs_data[$];
  bit                 obs_last[$];
  int                 obs_cyc[$];
  int                 stall_bad;
  bit                 inj_seen;
  logic [2:0]         inj_level;
  logic [BATCH_W-1:0] mf[$];
  int                 model_drops;
`ifdef DIFFTEST_RX_SEQ_HDR_EN
  logic [31:0]        model_seq = 32'd0;
`endif

  function automatic logic [BATCH_W-1:0] rand_batch();
    logic [BATCH_W-1:0] b;
    for (int k = 0; k < BATCH_W / 32; k++) b[32*k +: 32] = $urandom();
    return b;
  endfunction

  // Expected beats of one batch; every header in these scenarios is built while drop_cnt is 0.
  task automatic build_exp(input logic [BATCH_W-1:0] b);
`ifdef DIFFTEST_RX_SEQ_HDR_EN
    exp_q.push_back({16'hDA7A, 16'h0000, model_seq});
    exp_last.push_back(1'b0);
    model_seq = model_seq + 1;
`endif
    for (int k = 0; k < WORDS; k++) begin
      exp_q.push_back(b[64*k +: 64]);
      exp_last.push_back(k == WORDS - 1);
    end
  endtask

  task automatic send(input logic [BATCH_W-1:0] b);
    gw_data   = b;
    gw_enable = 1'b1;
    @(posedge sys_clk_i); #1;
    gw_enable = 1'b0;
  endtask

  // mode 0: tready=1, 1: toggles 1010.., 2: random. Optionally pushes inj_data on the first tlast handshake.
  task automatic capture(input int n, input int mode, input bit inj, input logic [BATCH_W-1:0] inj_data);
    int cyc = 0;
    bit held_v = 0;
    logic [63:0] held_d;
    bit held_l;
    bit injected = 0;
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    stall_bad = 0;
    inj_seen = 0;
    while (obs_data.size() < n && cyc < n * 4 + 50) begin
      case (mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = (cyc % 2 == 0);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge sys_clk_i);
      if (held_v && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_d || m_axis_tlast !== held_l))
        stall_bad++;
      if (m_axis_tvalid && m_axis_tready) begin
        obs_data.push_back(m_axis_tdata);
        obs_last.push_back(m_axis_tlast);
        obs_cyc.push_back(cyc);
        held_v = 0;
        if (inj && !injected && m_axis_tlast) begin
          gw_data = inj_data;
          gw_enable = 1'b1;
          injected = 1;
        end
      end else if (m_axis_tvalid) begin
        held_v = 1; held_d = m_axis_tdata; held_l = m_axis_tlast;
      end else begin
        held_v = 0;
      end
      @(posedge sys_clk_i); #1;
      if (gw_enable) begin
        inj_level = fifo_level;
        inj_seen = 1;
      end
      gw_enable = 1'b0;
      cyc++;
    end
    m_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); end
    total++; if (m_axis_tdata !== 64'd0) begin bad++; $display("FAIL reset_tdata got=%h want=0", m_axis_tdata); end
    total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", m_axis_tlast); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    @(negedge sys_clk_i) sys_rstn_i = 1'b1;
    @(posedge sys_clk_i); #1;
  endtask

  task automatic test_single();
    logic [BATCH_W-1:0] b;
    for (int k = 0; k < WORDS; k++) b[64*k +: 64] = 64'(k);
    exp_q.delete(); exp_last.delete();
    build_exp(b);
    send(b);
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL single_lat_early got=%b want=0", m_axis_tvalid); end
    @(posedge sys_clk_i); #1;
    total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL single_lat_on got=%b want=1", m_axis_tvalid); end
    capture(BPB, 0, 0, '0);
    total++; if (obs_data.size() != BPB) begin bad++; $display("FAIL single_count got=%0d want=%0d", obs_data.size(), BPB); end
    for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== exp_last[i]) begin
        bad++; $display("FAIL single_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_q[i], exp_last[i]);
      end
    end
    total++; if (obs_cyc.size() == BPB && obs_cyc[BPB-1] - obs_cyc[0] != BPB - 1) begin
      bad++; $display("FAIL single_rate got=%0d cycles want=%0d", obs_cyc[BPB-1] - obs_cyc[0], BPB - 1); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL single_level got=%0d want=0", fifo_level); end
  endtask

  task automatic test_backpressure();
    logic [BATCH_W-1:0] b = rand_batch();
    exp_q.delete(); exp_last.delete();
    build_exp(b);
    send(b);
    capture(BPB, 1, 0, '0);
    total++; if (obs_data.size() != BPB) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_data.size(), BPB); end
    for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== exp_last[i]) begin
        bad++; $display("FAIL bp_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_q[i], exp_last[i]);
      end
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_hold got=%0d unstable stalls want=0", stall_bad); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL bp_level got=%0d want=0", fifo_level); end
  endtask

  task automatic test_back_to_back();
    exp_q.delete(); exp_last.delete();
    for (int j = 0; j < 3; j++) begin
      logic [BATCH_W-1:0] b = rand_batch();
      build_exp(b);
      send(b);
    end
    capture(3 * BPB, 0, 0, '0);
    total++; if (obs_data.size() != 3 * BPB) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_data.size(), 3 * BPB); end
    for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== exp_last[i]) begin
        bad++; $display("FAIL b2b_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_q[i], exp_last[i]);
      end
    end
    total++; if (obs_cyc.size() == 3 * BPB && obs_cyc[3*BPB-1] - obs_cyc[0] != 3 * BPB - 1) begin
      bad++; $display("FAIL b2b_bubble got=%0d cycles want=%0d", obs_cyc[3*BPB-1] - obs_cyc[0], 3 * BPB - 1); end
  endtask

  task automatic test_overflow();
    exp_q.delete(); exp_last.delete(); mf.delete();
    model_drops = 0;
    for (int j = 0; j < 6; j++) begin
      logic [BATCH_W-1:0] b = rand_batch();
      if (mf.size() < FIFO_DEPTH) mf.push_back(b); else model_drops++;
      send(b);
    end
    total++; if (fifo_level !== 3'(mf.size())) begin bad++; $display("FAIL ovf_level got=%0d want=%0d", fifo_level, mf.size()); end
    total++; if (drop_cnt !== 16'(model_drops)) begin bad++; $display("FAIL ovf_drop got=%0d want=%0d", drop_cnt, model_drops); end
    total++; if (overflow !== (model_drops > 0)) begin bad++; $display("FAIL ovf_flag got=%b want=%b", overflow, model_drops > 0); end
    // clear and a dropped batch in the same cycle: clear wins
    gw_data = rand_batch(); gw_enable = 1'b1; clr_stat = 1'b1;
    @(posedge sys_clk_i); #1;
    gw_enable = 1'b0; clr_stat = 1'b0;
    model_drops = 0;
    total++; if (drop_cnt !== 16'(model_drops)) begin bad++; $display("FAIL clr_drop got=%0d want=0", drop_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%b want=0", overflow); end
    total++; if (fifo_level !== 3'(mf.size())) begin bad++; $display("FAIL clr_level got=%0d want=%0d", fifo_level, mf.size()); end
    foreach (mf[j]) build_exp(mf[j]);
    capture(FIFO_DEPTH * BPB, 2, 0, '0);
    total++; if (obs_data.size() != FIFO_DEPTH * BPB) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", obs_data.size(), FIFO_DEPTH * BPB); end
    for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== exp_last[i]) begin
        bad++; $display("FAIL ovf_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_q[i], exp_last[i]);
      end
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL ovf_hold got=%0d unstable stalls want=0", stall_bad); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL ovf_drain got=%0d want=0", fifo_level); end
  endtask

  task automatic test_full_pop();
    logic [BATCH_W-1:0] extra = rand_batch();
    exp_q.delete(); exp_last.delete(); mf.delete();
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      logic [BATCH_W-1:0] b = rand_batch();
      mf.push_back(b);
      send(b);
    end
    mf.push_back(extra);
    foreach (mf[j]) build_exp(mf[j]);
    capture((FIFO_DEPTH + 1) * BPB, 0, 1, extra);
    total++; if (!inj_seen || inj_level !== 3'(FIFO_DEPTH)) begin
      bad++; $display("FAIL fp_level got=%0d seen=%0d want=%0d", inj_level, inj_seen, FIFO_DEPTH); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL fp_drop got=%0d want=0", drop_cnt); end
    total++; if (obs_data.size() != (FIFO_DEPTH + 1) * BPB) begin
      bad++; $display("FAIL fp_count got=%0d want=%0d", obs_data.size(), (FIFO_DEPTH + 1) * BPB); end
    for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== exp_last[i]) begin
        bad++; $display("FAIL fp_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_q[i], exp_last[i]);
      end
    end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL fp_drain got=%0d want=0", fifo_level); end
  endtask

  task automatic test_reset_mid();
    logic [BATCH_W-1:0] b = rand_batch();
    exp_q.delete(); exp_last.delete();
    build_exp(b);
    send(b);
    capture(6, 0, 0, '0);
    total++; if (obs_data.size() != 6) begin bad++; $display("FAIL mid_count got=%0d want=6", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_data[i] !== exp_q[i]) begin bad++; $display("FAIL mid_beat%0d got=%h want=%h", i, obs_data[i], exp_q[i]); end
    end
    total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL mid_active got=%b want=1", m_axis_tvalid); end
    sys_rstn_i = 1'b0;
    #1;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL mid_tvalid got=%b want=0", m_axis_tvalid); end
    total++; if (m_axis_tdata !== 64'd0) begin bad++; $display("FAIL mid_tdata got=%h want=0", m_axis_tdata); end
    total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL mid_tlast got=%b want=0", m_axis_tlast); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", fifo_level); end
    @(negedge sys_clk_i) sys_rstn_i = 1'b1;
    @(posedge sys_clk_i); #1;
`ifdef DIFFTEST_RX_SEQ_HDR_EN
    model_seq = 32'd0;
`endif
    exp_q.delete(); exp_last.delete();
    b = rand_batch();
    build_exp(b);
    send(b);
    capture(BPB, 2, 0, '0);
    total++; if (obs_data.size() != BPB) begin bad++; $display("FAIL post_count got=%0d want=%0d", obs_data.size(), BPB); end
    for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== exp_last[i]) begin
        bad++; $display("FAIL post_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_q[i], exp_last[i]);
      end
    end
  endtask

  initial begin
    gw_data = '0;
    gw_enable = 1'b0;
    m_axis_tready = 1'b0;
    clr_stat = 1'b0;
    repeat (3) @(posedge sys_clk_i);
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
